// File: rtl/nibble_serial_adder_if.sv
// Request/response bundle for nibble_serial_adder.
// The sub signal exists only when NSA_SUB_EN is defined.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_in;
`ifdef NSA_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_out;

`ifdef NSA_SUB_EN
  modport master (
    output start, op_a, op_b, cin_in, sub,
    input  busy, done, result, cout_out
  );
  modport slave (
    input  start, op_a, op_b, cin_in, sub,
    output busy, done, result, cout_out
  );
`else
  modport master (
    output start, op_a, op_b, cin_in,
    input  busy, done, result, cout_out
  );
  modport slave (
    input  start, op_a, op_b, cin_in,
    output busy, done, result, cout_out
  );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add sequenced one nibble per clock through an external 4-bit adder.
// Define NSA_SUB_EN to add the sub request (A - B via ~B + 1).
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus,
  output logic [3:0]            add_a,
  output logic [3:0]            add_b,
  output logic                  add_cin,
  input  logic [3:0]            add_sum,
  input  logic                  add_cout
);

  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned IdxW = (Nib > 1) ? $clog2(Nib) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [Nib-1:0][3:0]   a_q, a_d;
  logic [Nib-1:0][3:0]   b_q, b_d;
  logic [Nib-1:0][3:0]   res_q, res_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;
  logic                  accept;
  logic                  last;

  // start is only honoured outside RUN, so in-flight operands are never disturbed
  assign accept = bus.start && (state_q != StRun);
  assign last   = (idx_q == IdxW'(Nib - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    add_a    = 4'h0;
    add_b    = 4'h0;
    add_cin  = 1'b0;
    unique case (state_q)
      StRun: begin
        bus.busy = 1'b1;
        add_a    = a_q[idx_q];
        add_b    = b_q[idx_q];
        add_cin  = carry_q;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    if (accept) begin
      a_d     = bus.op_a;
      b_d     = bus.op_b;
      carry_d = bus.cin_in;
      idx_d   = '0;
`ifdef NSA_SUB_EN
      if (bus.sub) begin
        b_d     = ~bus.op_b;
        carry_d = 1'b1;
      end
`endif
    end else if (state_q == StRun) begin
      res_d[idx_q] = add_sum;
      carry_d      = add_cout;
      if (last) begin
        cout_d = add_cout;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.result   = res_q;
  assign bus.cout_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder; the bench supplies the 4-bit adder model.
module tb_nibble_serial_adder;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) nsa ();

  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;

  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (nsa),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  typedef struct packed {
    logic [15:0] res;
    logic        co;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic drive_start(input logic [15:0] a, input logic [15:0] b, input logic cin,
                             input logic sub, input bit track);
    logic [16:0] s;
    nsa.start  = 1'b1;
    nsa.op_a   = a;
    nsa.op_b   = b;
    nsa.cin_in = cin;
`ifdef NSA_SUB_EN
    nsa.sub    = sub;
`endif
    if (sub) s = {1'b0, a} + {1'b0, ~b} + 17'd1;
    else     s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    if (track) sb.push_back({s[15:0], s[16]});
  endtask

  // Observes one operation; lat counts negedges after the accept edge until done (-1: timeout).
  task automatic collect(input int inject_at, input bit chain, input logic [15:0] na,
                         input logic [15:0] nb, input logic ncin, input logic nsub,
                         output int lat, output int busy_cnt, output logic [7:0] cin_seq,
                         output logic [15:0] res, output logic co);
    lat = -1; busy_cnt = 0; cin_seq = '0; res = '0; co = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      nsa.start = 1'b0;
      if (k == inject_at) drive_start(16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b0);
      if (nsa.busy === 1'b1) begin
        if (busy_cnt < 8) cin_seq[busy_cnt] = add_cin;
        busy_cnt++;
      end
      if (nsa.done === 1'b1) begin
        lat = k;
        res = nsa.result;
        co  = nsa.cout_out;
        if (chain) drive_start(na, nb, ncin, nsub, 1'b1);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nsa.start = 1'b0; nsa.op_a = '0; nsa.op_b = '0; nsa.cin_in = 1'b0;
`ifdef NSA_SUB_EN
    nsa.sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    total++;
    if ({nsa.busy, nsa.done} !== 2'b00)
      $display("FAIL reset_flags: busy/done got %b expected 00", {nsa.busy, nsa.done});
    else passed++;
    total++;
    if ({nsa.result, nsa.cout_out} !== 17'd0)
      $display("FAIL reset_result: got %h/%b expected 0000/0", nsa.result, nsa.cout_out);
    else passed++;
    total++;
    if ({add_a, add_b, add_cin} !== 9'd0)
      $display("FAIL reset_adder_pins: got %h %h %b expected 0 0 0", add_a, add_b, add_cin);
    else passed++;
    drive_start(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    total++;
    if (nsa.busy !== 1'b0) $display("FAIL reset_wins: busy got %b expected 0", nsa.busy);
    else passed++;
    nsa.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    int lat, bc; logic [7:0] cs; logic [15:0] r; logic c; exp_t e;
    drive_start(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    collect(0, 1'b0, '0, '0, 1'b0, 1'b0, lat, bc, cs, r, c);
    e = sb.pop_front();
    total++;
    if (lat !== 5) $display("FAIL basic_latency: got %0d expected 5", lat); else passed++;
    total++;
    if (bc !== 4) $display("FAIL basic_busy_cycles: got %0d expected 4", bc); else passed++;
    total++;
    if (r !== e.res) $display("FAIL basic_result: got %h expected %h", r, e.res); else passed++;
    total++;
    if (c !== e.co) $display("FAIL basic_cout: got %b expected %b", c, e.co); else passed++;
    @(negedge clk);
    total++;
    if (nsa.done !== 1'b0 || nsa.result !== e.res)
      $display("FAIL basic_hold: done %b result %h expected 0 %h", nsa.done, nsa.result, e.res);
    else passed++;
  endtask

  task automatic test_carry_ripple();
    int lat, bc; logic [7:0] cs; logic [15:0] r; logic c; exp_t e;
    drive_start(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    collect(0, 1'b0, '0, '0, 1'b0, 1'b0, lat, bc, cs, r, c);
    e = sb.pop_front();
    total++;
    if (r !== e.res || c !== e.co)
      $display("FAIL ripple_result: got %h/%b expected %h/%b", r, c, e.res, e.co);
    else passed++;
    total++;
    if (cs[3:0] !== 4'b1110)
      $display("FAIL ripple_cin_seq: got %b expected 1110 (lsb first)", cs[3:0]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [7:0] cs; logic [15:0] r; logic c; exp_t e;
    drive_start(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    collect(0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, lat, bc, cs, r, c);
    e = sb.pop_front();
    total++;
    if (r !== e.res || c !== e.co || lat !== 5)
      $display("FAIL b2b_first: got %h/%b lat %0d expected %h/%b lat 5", r, c, lat, e.res, e.co);
    else passed++;
    collect(0, 1'b0, '0, '0, 1'b0, 1'b0, lat, bc, cs, r, c);
    e = sb.pop_front();
    total++;
    if (lat !== 5) $display("FAIL b2b_latency: got %0d expected 5", lat); else passed++;
    total++;
    if (r !== e.res || c !== e.co)
      $display("FAIL b2b_second: got %h/%b expected %h/%b", r, c, e.res, e.co);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int lat, bc, extra; logic [7:0] cs; logic [15:0] r; logic c; exp_t e;
    drive_start(16'h00A5, 16'h005A, 1'b0, 1'b0, 1'b1);
    collect(2, 1'b0, '0, '0, 1'b0, 1'b0, lat, bc, cs, r, c);
    e = sb.pop_front();
    total++;
    if (r !== e.res || c !== e.co || lat !== 5)
      $display("FAIL busy_ignore_result: got %h/%b lat %0d expected %h/%b lat 5",
               r, c, lat, e.res, e.co);
    else passed++;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (nsa.done === 1'b1 || nsa.busy === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL busy_ignore_extra: got %0d active cycles expected 0", extra);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    int lat, bc; logic [7:0] cs; logic [15:0] r; logic c; exp_t e;
    drive_start(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    nsa.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    total++;
    if ({nsa.busy, nsa.done, nsa.result, nsa.cout_out, add_a, add_b, add_cin} !== 28'd0)
      $display("FAIL midrst_outputs: busy %b done %b result %h cout %b adder %h %h %b expected 0",
               nsa.busy, nsa.done, nsa.result, nsa.cout_out, add_a, add_b, add_cin);
    else passed++;
    drive_start(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1);
    collect(0, 1'b0, '0, '0, 1'b0, 1'b0, lat, bc, cs, r, c);
    e = sb.pop_front();
    total++;
    if (r !== e.res || c !== e.co || lat !== 5)
      $display("FAIL midrst_next: got %h/%b lat %0d expected %h/%b lat 5", r, c, lat, e.res, e.co);
    else passed++;
  endtask

`ifdef NSA_SUB_EN
  task automatic test_subtract();
    int lat, bc; logic [7:0] cs; logic [15:0] r; logic c; exp_t e;
    drive_start(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    collect(0, 1'b0, '0, '0, 1'b0, 1'b0, lat, bc, cs, r, c);
    e = sb.pop_front();
    total++;
    if (r !== e.res || c !== e.co)
      $display("FAIL sub_borrow: got %h/%b expected %h/%b", r, c, e.res, e.co);
    else passed++;
    @(negedge clk);
    drive_start(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
    collect(0, 1'b0, '0, '0, 1'b0, 1'b0, lat, bc, cs, r, c);
    e = sb.pop_front();
    total++;
    if (r !== e.res || c !== e.co)
      $display("FAIL sub_noborrow: got %h/%b expected %h/%b", r, c, e.res, e.co);
    else passed++;
    nsa.sub = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_back_to_back();
    @(negedge clk);
    test_start_while_busy();
    test_reset_mid_op();
`ifdef NSA_SUB_EN
    @(negedge clk);
    test_subtract();
`endif
    total++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
